uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first: mid-bit sampling, pushes each good byte to the
// receive FIFO, and flags and drops frames whose stop bit is sampled low.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       push,
  output logic       ferr,
  output logic       busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitidx_q, bitidx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             push_q, push_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;

  logic rxd_s;
  logic half_done_c;
  logic bit_done_c;

  // Two-flop synchronizer; line idles high so reset to 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd};
    end
  end

  assign rxd_s       = sync_q[1];
  assign half_done_c = (cnt_q == HALF_LAST);
  assign bit_done_c  = (cnt_q == BIT_LAST);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rxd_s) state_d = S_START;
      S_START: if (half_done_c) state_d = rxd_s ? S_IDLE : S_DATA;
      S_DATA:  if (bit_done_c && (bitidx_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (bit_done_c) state_d = rxd_s ? S_IDLE : S_BREAK;
      S_BREAK: if (rxd_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d    = cnt_q;
    bitidx_d = bitidx_q;
    shift_d  = shift_q;
    rdata_d  = rdata_q;
    push_d   = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
      end
      S_START: begin
        if (half_done_c) begin
          cnt_d    = '0;
          bitidx_d = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_done_c) begin
          cnt_d    = '0;
          bitidx_d = bitidx_q + 3'd1;
          shift_d  = {rxd_s, shift_q[7:1]};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_done_c) begin
          cnt_d = '0;
          if (rxd_s) begin
            rdata_d = shift_q;
            push_d  = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      bitidx_q <= 3'd0;
      shift_q  <= 8'h00;
      rdata_q  <= 8'h00;
      push_q   <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      bitidx_q <= bitidx_d;
      shift_q  <= shift_d;
      rdata_q  <= rdata_d;
      push_q   <= push_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
    end
  end

  assign rdata = rdata_q;
  assign push  = push_q;
  assign ferr  = ferr_q;
  assign busy  = busy_q;

`ifndef SYNTHESIS
  // Pulse and data-hold guarantees the FIFO relies on.
  a_push_ferr_excl : assert property (@(posedge clk) disable iff (!rstn)
    !(push_q && ferr_q));
  a_no_back_to_back : assert property (@(posedge clk) disable iff (!rstn)
    (push_q || ferr_q) |=> !(push_q || ferr_q));
  a_rdata_hold : assert property (@(posedge clk) disable iff (!rstn)
    (rdata_q != $past(rdata_q)) |-> push_q);
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a frame-level model predicts each push/ferr event
// (byte, kind, cycle) and a per-cycle compare process checks both DUT instances.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned CPB_A = 16;
  localparam int unsigned CPB_B = 100;
  // Pulse appears 2 sync cycles + half a bit + 9 bits + 1 register after the falling edge.
  localparam longint LAT_A = longint'(3 + CPB_A / 2 + 9 * CPB_A);
  localparam longint LAT_B = longint'(3 + CPB_B / 2 + 9 * CPB_B);

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       rxd_a = 1'b1;
  logic       rxd_b = 1'b1;
  logic [7:0] rdata_a, rdata_b;
  logic       push_a, push_b, ferr_a, ferr_b, busy_a, busy_b;

  uart_rx #(.CLKS_PER_BIT(CPB_A)) u_dut_a (
    .clk(clk), .rstn(rstn), .rxd(rxd_a),
    .rdata(rdata_a), .push(push_a), .ferr(ferr_a), .busy(busy_a)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_B)) u_dut_b (
    .clk(clk), .rstn(rstn), .rxd(rxd_b),
    .rdata(rdata_b), .push(push_b), .ferr(ferr_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_push;
    logic [7:0] data;
    longint     due;
  } exp_t;

  exp_t       expq [2][$];
  logic [7:0] last_rdata [2];
  int         push_cnt [2];
  int         ferr_cnt [2];
  int         busy_cnt [2];
  longint     last_push_cyc [2];
  bit         prev_pulse [2];
  int         vectors     = 0;
  int         miscompares = 0;
  longint     cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic report(input string name, input string got, input string want);
    miscompares++;
    $display("FAIL %s cyc=%0d got=%s want=%s", name, cyc, got, want);
  endtask

  task automatic check_val(input string name, input longint got, input longint want);
    vectors++;
    if (got != want) report(name, $sformatf("%0h", got), $sformatf("%0h", want));
  endtask

  task automatic check_range(input string name, input longint got, input longint lo, input longint hi);
    vectors++;
    if (got < lo || got > hi) report(name, $sformatf("%0d", got), $sformatf("%0d..%0d", lo, hi));
  endtask

  // Per-cycle comparison of one instance against the model.
  task automatic check_inst(input int id, input logic [7:0] rd, input logic p, input logic f,
                            input logic b);
    exp_t e;
    vectors++;
    if (!rstn) begin
      if (rd !== 8'h00 || p !== 1'b0 || f !== 1'b0 || b !== 1'b0)
        report($sformatf("reset_state[%0d]", id), $sformatf("%h/%b/%b/%b", rd, p, f, b), "00/0/0/0");
      prev_pulse[id] = 1'b0;
      return;
    end
    if (b === 1'b1) busy_cnt[id]++;
    if (p === 1'b1 && f === 1'b1) report($sformatf("push_and_ferr[%0d]", id), "11", "not both");
    if (prev_pulse[id] && (p === 1'b1 || f === 1'b1))
      report($sformatf("consecutive_pulse[%0d]", id), "pulse", "gap");
    prev_pulse[id] = (p === 1'b1) || (f === 1'b1);
    if (p === 1'b1 || f === 1'b1) begin
      if (p === 1'b1) begin
        push_cnt[id]++;
        last_push_cyc[id] = cyc;
      end else begin
        ferr_cnt[id]++;
      end
      if (expq[id].size() == 0) begin
        report($sformatf("unexpected_pulse[%0d]", id), $sformatf("push=%b ferr=%b", p, f), "none");
      end else begin
        e = expq[id].pop_front();
        if (e.is_push != (p === 1'b1))
          report($sformatf("pulse_kind[%0d]", id), $sformatf("push=%b", p), $sformatf("push=%b", e.is_push));
        if (cyc < e.due - 1 || cyc > e.due + 1)
          report($sformatf("pulse_time[%0d]", id), $sformatf("%0d", cyc), $sformatf("%0d+-1", e.due));
        if (e.is_push) begin
          if (rd !== e.data) report($sformatf("push_data[%0d]", id), $sformatf("%h", rd), $sformatf("%h", e.data));
          last_rdata[id] = e.data;
        end
        // A good stop returns to idle; a bad stop with the line low waits in break.
        if (b !== f) report($sformatf("busy_at_pulse[%0d]", id), $sformatf("%b", b), $sformatf("%b", f));
      end
    end else if (expq[id].size() != 0 && cyc > expq[id][0].due + 1) begin
      report($sformatf("missing_pulse[%0d]", id), "none", $sformatf("pulse by %0d", expq[id][0].due + 1));
      void'(expq[id].pop_front());
    end
    if (p !== 1'b1 && rd !== last_rdata[id])
      report($sformatf("rdata_hold[%0d]", id), $sformatf("%h", rd), $sformatf("%h", last_rdata[id]));
  endtask

  always @(negedge clk) begin
    check_inst(0, rdata_a, push_a, ferr_a, busy_a);
    check_inst(1, rdata_b, push_b, ferr_b, busy_b);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int id, input logic v);
    if (id == 0) rxd_a = v;
    else         rxd_b = v;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      push_cnt[i] = 0;
      ferr_cnt[i] = 0;
      busy_cnt[i] = 0;
    end
  endtask

  // Transmit one frame with bt cycles per bit; line is left at the stop level.
  task automatic send_frame(input int id, input logic [7:0] data, input logic stop, input int bt);
    exp_t e;
    e.is_push = stop;
    e.data    = data;
    e.due     = cyc + ((id == 0) ? LAT_A : LAT_B);
    expq[id].push_back(e);
    set_line(id, 1'b0);
    tick(bt);
    for (int i = 0; i < 8; i++) begin
      set_line(id, data[i]);
      tick(bt);
    end
    set_line(id, stop);
    tick(bt);
  endtask

  task automatic drain(input int id, input int budget);
    int n;
    n = 0;
    while (expq[id].size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    vectors++;
    if (expq[id].size() != 0) begin
      report($sformatf("drain_timeout[%0d]", id), $sformatf("%0d left", expq[id].size()), "0 left");
      expq[id].delete();
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rb;
    longint     t0;
    int         bts [2];
    last_rdata[0] = 8'h00;
    last_rdata[1] = 8'h00;
    clear_counts();

    rstn = 1'b0;
    tick(5);
    rstn = 1'b1;
    tick(5);

    // Single frame with ideal timing
    clear_counts();
    t0 = cyc;
    send_frame(0, 8'hA5, 1'b1, CPB_A);
    drain(0, 200);
    tick(5);
    check_range("t1_latency", last_push_cyc[0] - t0, 154, 156);
    check_val("t1_rdata", longint'(rdata_a), 64'hA5);
    check_val("t1_push_cnt", push_cnt[0], 1);
    check_val("t1_ferr_cnt", ferr_cnt[0], 0);

    // Back-to-back frames
    clear_counts();
    send_frame(0, 8'h00, 1'b1, CPB_A);
    send_frame(0, 8'hFF, 1'b1, CPB_A);
    send_frame(0, 8'h3C, 1'b1, CPB_A);
    drain(0, 200);
    tick(5);
    check_val("t2_push_cnt", push_cnt[0], 3);
    check_val("t2_rdata", longint'(rdata_a), 64'h3C);

    // Framing error followed by a held-low break
    clear_counts();
    send_frame(0, 8'h55, 1'b0, CPB_A);
    tick(40);
    check_val("t3_busy_in_break", longint'(busy_a), 1);
    check_val("t3_ferr_cnt", ferr_cnt[0], 1);
    check_val("t3_push_cnt", push_cnt[0], 0);
    check_val("t3_rdata_kept", longint'(rdata_a), 64'h3C);
    set_line(0, 1'b1);
    tick(4);
    check_val("t3_idle_after_break", longint'(busy_a), 0);
    tick(10);
    clear_counts();
    send_frame(0, 8'h12, 1'b1, CPB_A);
    drain(0, 200);
    tick(5);
    check_val("t3_next_push_cnt", push_cnt[0], 1);
    check_val("t3_next_rdata", longint'(rdata_a), 64'h12);

    // Short glitch on the idle line
    clear_counts();
    set_line(0, 1'b0);
    tick(3);
    set_line(0, 1'b1);
    tick(30);
    check_val("t4_busy_cycles", busy_cnt[0], 8);
    check_val("t4_push_cnt", push_cnt[0], 0);
    check_val("t4_ferr_cnt", ferr_cnt[0], 0);

    // Transmitter 4% slow and 4% fast against a 100-cycle bit period
    clear_counts();
    bts[0] = 96;
    bts[1] = 104;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 12; i++) begin
        rb = 8'($urandom);
        send_frame(1, rb, 1'b1, bts[k]);
      end
    end
    drain(1, 2000);
    tick(20);
    check_val("t5_push_cnt", push_cnt[1], 24);
    check_val("t5_ferr_cnt", ferr_cnt[1], 0);

    // Reset in the middle of a data phase
    clear_counts();
    set_line(0, 1'b0);
    tick(CPB_A);
    for (int i = 0; i < 3; i++) begin
      set_line(0, 1'(8'h77 >> i));
      tick(CPB_A);
    end
    rstn = 1'b0;
    expq[0].delete();
    expq[1].delete();
    last_rdata[0] = 8'h00;
    last_rdata[1] = 8'h00;
    set_line(0, 1'b1);
    #2;
    check_val("t6_rst_rdata", longint'(rdata_a), 0);
    check_val("t6_rst_busy", longint'(busy_a), 0);
    tick(3);
    rstn = 1'b1;
    tick((CPB_A * 10));
    check_val("t6_no_push_77", push_cnt[0], 0);
    send_frame(0, 8'h81, 1'b1, CPB_A);
    drain(0, 200);
    tick(5);
    check_val("t6_push_cnt", push_cnt[0], 1);
    check_val("t6_rdata", longint'(rdata_a), 64'h81);

    drain(0, 10);
    drain(1, 10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
